adc_control: RTL and testbench

ADC_CONTROL -- requirements
Module: adc_control

---
 rtl/adc_control_pkg.sv | 29 ++
 rtl/adc_control_if.sv | 10 +
 rtl/adc_sclk_gen.sv | 46 ++++
 rtl/adc_control.sv | 106 ++++++++++
 tb/tb_adc_control.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_control_pkg.sv
// Shared types and constants for the serial ADC controller: FSM states,
// frame geometry and the slots that carry the channel address on DIN.
package adc_control_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int FRAME_BITS        = 16;
    localparam int DATA_BITS         = 12;
    localparam int CH_BITS           = 3;
    localparam int SCLK_HALF_DEFAULT = 10;

    // CH_BIT_POS[i] is the SCLK bit slot that carries ch[i] (ch[2] goes first).
    localparam logic [CH_BITS-1:0][3:0] CH_BIT_POS = {4'd2, 4'd3, 4'd4};

    function automatic logic din_for_bit(input logic [3:0] bit_idx,
                                         input logic [CH_BITS-1:0] ch);
        logic b;
        b = 1'b0;
        for (int i = 0; i < CH_BITS; i++) begin
            if (bit_idx == CH_BIT_POS[i]) b = ch[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_control_if.sv
// Serial link between the controller (master) and the ADC (slave).
interface adc_control_if;
    logic oCS_n;
    logic oSCLK;
    logic oDIN;
    logic iDOUT;

    modport master (output oCS_n, output oSCLK, output oDIN, input iDOUT);
    modport slave  (input oCS_n, input oSCLK, input oDIN, output iDOUT);
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK generator: SCLK_HALF cycles low then SCLK_HALF cycles high while run is
// set; fall/rise strobe the cycle before the registered SCLK changes level.
module adc_sclk_gen
    import adc_control_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic start,
    input  logic run,
    input  logic stop,
    output logic sclk,
    output logic fall,
    output logic rise
);

    localparam int CW = $clog2(SCLK_HALF);

    logic [CW-1:0] half_cnt;
    logic          half_end;

    assign half_end = (half_cnt == CW'(SCLK_HALF - 1));
    assign rise     = run && half_end && !sclk;
    assign fall     = run && half_end && sclk;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sclk     <= 1'b1;
            half_cnt <= '0;
        end else if (start) begin
            sclk     <= 1'b0;
            half_cnt <= '0;
        end else if (stop || !run) begin
            sclk     <= 1'b1;
            half_cnt <= '0;
        end else if (half_end) begin
            sclk     <= ~sclk;
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_control.sv
// Continuous-conversion controller for a 16-clock serial ADC frame: sends the
// channel address on DIN, captures DOUT and publishes the 12-bit result.
module adc_control
    import adc_control_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iGO,
    input  logic [CH_BITS-1:0]   iCH,
    adc_control_if.master        adc,
    output logic [DATA_BITS-1:0] odata,
    output logic                 en_data
);

    localparam int GW = $clog2(2 * SCLK_HALF);

    state_t                state_q, state_d;
    logic                  cs_n_q, cs_n_d;
    logic                  din_q, din_d;
    logic [CH_BITS-1:0]    ch_reg;
    logic [3:0]            bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  sclk, fall, rise;
    logic                  in_conv, start, frame_end, gap_end;

    assign in_conv   = (state_q == CONV);
    assign start     = (state_q == IDLE) && iGO;
    assign frame_end = in_conv && fall && (bit_cnt == 4'(FRAME_BITS - 1));
    assign gap_end   = (state_q == GAP) && (gap_cnt == GW'(2 * SCLK_HALF - 1));

    adc_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .start (start),
        .run   (in_conv),
        .stop  (frame_end),
        .sclk  (sclk),
        .fall  (fall),
        .rise  (rise)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            din_q   <= din_d;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iGO) state_d = CONV;
            CONV:    if (frame_end) state_d = GAP;
            GAP:     if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DIN changes together with each SCLK fall; bit 0 never carries address.
    always_comb begin
        cs_n_d = (state_d != CONV);
        din_d  = din_q;
        if (state_d != CONV || start) din_d = 1'b0;
        else if (fall)                din_d = din_for_bit(bit_cnt + 4'd1, ch_reg);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ch_reg  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            odata   <= '0;
            en_data <= 1'b0;
        end else begin
            en_data <= frame_end;
            if (frame_end) odata <= shift[DATA_BITS-1:0];

            if (start) begin
                ch_reg  <= iCH;
                bit_cnt <= '0;
            end else if (in_conv && fall) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (in_conv && rise) shift <= {shift[FRAME_BITS-2:0], adc.iDOUT};

            if (state_q == GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= '0;
        end
    end

    assign adc.oCS_n = cs_n_q;
    assign adc.oSCLK = sclk;
    assign adc.oDIN  = din_q;

endmodule

// File: tb/tb_adc_control.sv
// Self-checking bench: cycle-level timeline model of the frame plus an ADC
// responder that tags results with the previous frame's channel.
module tb_adc_control;
    import adc_control_pkg::*;

    localparam int H     = 10;
    localparam int FRAME = 34 * H + 1;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iGO;
    logic [2:0]  iCH;
    logic [11:0] odata;
    logic        en_data;

    adc_control_if adc();

    adc_control #(.SCLK_HALF(H)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iGO     (iGO),
        .iCH     (iCH),
        .adc     (adc),
        .odata   (odata),
        .en_data (en_data)
    );

    always #5 iCLK = ~iCLK;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always @(posedge iCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ADC responder ----------------
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    int          rk = 0;
    logic [15:0] word = '0;
    logic [15:0] din_bits = '0, last_din_bits = '0;
    logic [2:0]  dec_ch = '0, prev_dec = '0;
    logic [15:0] force_q[$];
    bit          fr_forced = 1'b0;
    logic [11:0] fr_val = '0;
    logic [8:0]  fr_pay = '0;

    always @(negedge iCLK) begin : resp
        if (iRST) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            rk        = 0;
            prev_dec  = '0;
            adc.iDOUT = 1'b0;
        end else begin
            if (prev_cs && !adc.oCS_n) begin
                rk       = 0;
                din_bits = '0;
                if (force_q.size() > 0) begin
                    word      = force_q.pop_front();
                    fr_forced = 1'b1;
                    fr_val    = word[11:0];
                end else begin
                    fr_forced = 1'b0;
                    fr_pay    = 9'($urandom);
                    word      = {4'($urandom), prev_dec, fr_pay};
                end
            end
            if (!adc.oCS_n && prev_sclk && !adc.oSCLK) adc.iDOUT = word[15-rk];
            if (!adc.oCS_n && !prev_sclk && adc.oSCLK) begin
                din_bits[15-rk] = adc.oDIN;
                if (rk == 4) dec_ch = din_bits[13:11];
                rk++;
            end
            if (!prev_cs && adc.oCS_n) begin
                last_din_bits = din_bits;
                prev_dec      = dec_ch;
            end
            prev_cs   = adc.oCS_n;
            prev_sclk = adc.oSCLK;
        end
    end

    // ---------------- timeline model ----------------
    bit         m_in = 1'b0;
    int         m_t = 0;
    logic [2:0] m_ch = '0, m_prev_ch = '0;
    logic [11:0] m_odata = '0;

    always @(posedge iCLK or posedge iRST) begin : model
        if (iRST) begin
            m_in = 1'b0; m_t = 0; m_ch = '0; m_prev_ch = '0; m_odata = '0;
        end else if (!m_in) begin
            if (iGO) begin m_in = 1'b1; m_t = 0; m_ch = iCH; end
        end else begin
            m_t++;
            if (m_t == 32 * H) begin
                m_odata   = fr_forced ? fr_val : {m_prev_ch, fr_pay};
                m_prev_ch = m_ch;
            end
            if (m_t == 34 * H) m_in = 1'b0;
        end
    end

    function automatic logic exp_din(input int t, input logic [2:0] ch);
        case (t / (2 * H))
            2:       return ch[2];
            3:       return ch[1];
            4:       return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge iCLK) begin : cmp
        logic conv, e_cs, e_sclk, e_din, e_en;
        conv   = m_in && (m_t < 32 * H);
        e_cs   = !conv;
        e_sclk = conv ? ((m_t % (2 * H)) >= H) : 1'b1;
        e_din  = conv ? exp_din(m_t, m_ch) : 1'b0;
        e_en   = m_in && (m_t == 32 * H);
        check("cs_n",    32'(adc.oCS_n), 32'(e_cs));
        check("sclk",    32'(adc.oSCLK), 32'(e_sclk));
        check("din",     32'(adc.oDIN),  32'(e_din));
        check("en_data", 32'(en_data),   32'(e_en));
        check("odata",   32'(odata),     32'(m_odata));
    end

    // ---------------- monitors ----------------
    int cs_low_run = 0, last_cs_run = 0, cs_falls = 0;
    int en_count = 0, en_t_last = 0, en_t_prev = 0;

    always @(negedge iCLK) begin : mon
        if (!adc.oCS_n) begin
            if (cs_low_run == 0) cs_falls++;
            cs_low_run++;
        end else begin
            if (cs_low_run > 0) last_cs_run = cs_low_run;
            cs_low_run = 0;
        end
        if (en_data) begin
            en_count++;
            en_t_prev = en_t_last;
            en_t_last = cyc;
        end
    end

    task automatic wait_en(input string what);
        int n;
        n = 0;
        do begin @(negedge iCLK); n++; end while (!en_data && n < 2 * FRAME);
        if (!en_data) check({what, "_timeout"}, 32'(en_data), 32'd1);
        @(negedge iCLK);
    endtask

    task automatic wait_bit(input int k, input string what);
        int n;
        n = 0;
        while (!(rk == k && adc.oCS_n == 1'b0) && n < 2 * FRAME) begin
            @(negedge iCLK); n++;
        end
        if (n >= 2 * FRAME) check({what, "_timeout"}, 32'(rk), 32'(k));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0, f0;
        iRST = 1'b1; iGO = 1'b0; iCH = 3'd0;
        repeat (3) @(negedge iCLK);
        check("rst_cs_n",  32'(adc.oCS_n), 32'd1);
        check("rst_sclk",  32'(adc.oSCLK), 32'd1);
        check("rst_din",   32'(adc.oDIN),  32'd0);
        check("rst_odata", 32'(odata),     32'd0);
        check("rst_en",    32'(en_data),   32'd0);
        #2 iRST = 1'b0;

        // First frame: channel 0 requested, responder returns 0xABC
        force_q.push_back(16'h0ABC);
        @(negedge iCLK); iGO = 1'b1;
        wait_en("f1");
        check("f1_odata",  32'(odata),     32'h0ABC);
        check("f1_cs_low", 32'(last_cs_run), 32'd320);
        check("f1_en_cnt", 32'(en_count),  32'd1);

        // Channel 5 requested; its result arrives one frame later
        iCH = 3'd5;
        wait_en("f2");
        check("f2_din_ch",  32'(last_din_bits[13:11]), 32'b101);
        check("f2_period",  32'(en_t_last - en_t_prev), 32'd341);
        wait_en("f3");
        check("f3_ch_tag",  32'(odata[11:9]), 32'd5);
        check("f3_period",  32'(en_t_last - en_t_prev), 32'd341);

        // Extreme codes with hostile leading nibbles
        force_q.push_back(16'h0FFF);
        force_q.push_back(16'hF000);
        wait_en("f4");
        check("f4_odata", 32'(odata), 32'h0FFF);
        wait_en("f5");
        check("f5_odata", 32'(odata), 32'h0000);

        // Random channel changes and short iGO dropouts
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge iCLK);
            if ($urandom_range(0, 49) == 0) iCH = 3'($urandom);
            if ($urandom_range(0, 199) == 0) iGO = ~iGO;
        end
        iGO = 1'b1;

        // iGO dropped mid-frame at bit 7
        wait_bit(7, "go_drop");
        iGO = 1'b0;
        c0 = en_count; f0 = cs_falls;
        repeat (3 * FRAME) @(negedge iCLK);
        check("drop_en_once",  32'(en_count - c0), 32'd1);
        check("drop_no_frame", 32'(cs_falls - f0), 32'd0);
        check("drop_cs_high",  32'(adc.oCS_n),     32'd1);

        // Reset mid-frame at bit 10
        @(negedge iCLK); iGO = 1'b1;
        wait_bit(10, "rst_mid");
        c0 = en_count;
        #2 iRST = 1'b1;
        #1;
        check("arst_cs_n",  32'(adc.oCS_n), 32'd1);
        check("arst_sclk",  32'(adc.oSCLK), 32'd1);
        check("arst_din",   32'(adc.oDIN),  32'd0);
        check("arst_odata", 32'(odata),     32'd0);
        check("arst_en",    32'(en_data),   32'd0);
        force_q.delete();
        force_q.push_back(16'h35A5);
        repeat (3) @(negedge iCLK);
        check("arst_no_en", 32'(en_count - c0), 32'd0);
        #2 iRST = 1'b0;
        wait_en("post_rst");
        check("post_rst_odata",  32'(odata),       32'h05A5);
        check("post_rst_cs_low", 32'(last_cs_run), 32'd320);

        repeat (5) @(negedge iCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
